// File: rtl/wb_arbiter.sv
// Writeback arbiter: greedy rotating-priority selection of up to wwd results
// from nfu execution queues, with prefix-shaped claims and registered wb ports.

package wb_pkg;
    typedef struct packed {
        logic [15:0] opid;
        logic [31:0] npc;
        logic [4:0]  cause;
        logic [31:0] prdv;
    } exe_bundle_t;
endpackage

module wb_arbiter
    import wb_pkg::*;
#(
    parameter int nfu = 3,
    parameter int ewd = 4,
    parameter int wwd = 4,
    localparam int PW = (nfu > 1) ? $clog2(nfu) : 1,
    localparam int SW = (wwd > 1) ? $clog2(wwd) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          stall,
    input  exe_bundle_t [nfu-1:0][ewd-1:0] resp,
    output logic [nfu-1:0][ewd-1:0]       claim,
    output exe_bundle_t [wwd-1:0]         wb,
    output logic [PW-1:0]                 prio
);

    exe_bundle_t [wwd-1:0] sel_p0;
    exe_bundle_t [wwd-1:0] wb_p1;
    logic                  contend_p0;
    logic                  suppress;
    logic                  run;
    int                    cnt;
    int                    u;

    assign suppress = rst | stall | flush;

    // Stage p0: scan units from prio, taking each unit's valid prefix until slots run out
    always_comb begin
        claim      = '0;
        sel_p0     = '0;
        contend_p0 = 1'b0;
        cnt        = 0;
        u          = 0;
        run        = 1'b0;
        for (int k = 0; k < nfu; k++) begin
            u = int'(prio) + k;
            if (u >= nfu) u = u - nfu;
            run = 1'b1;
            for (int i = 0; i < ewd; i++) begin
                if (run && !suppress && resp[PW'(u)][i].opid[15] && (cnt < wwd)) begin
                    claim[PW'(u)][i]   = 1'b1;
                    sel_p0[SW'(cnt)]   = resp[PW'(u)][i];
                    cnt                = cnt + 1;
                end else begin
                    run = 1'b0;
                    if (!suppress && resp[PW'(u)][i].opid[15]) contend_p0 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= '0;
        end else if (contend_p0) begin
            prio <= (prio == PW'(nfu - 1)) ? '0 : prio + 1'b1;
        end
    end

    // Stage p1: writeback register, cleared on rst/flush, frozen on stall
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wb_p1 <= '0;
        end else if (!stall) begin
            wb_p1 <= sel_p0;
        end
    end

    assign wb = wb_p1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: driver queues expected claim/prio/wb per cycle,
// a negedge monitor pops and compares against the DUT.

module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int NFU = 3;
    localparam int EWD = 4;
    localparam int WWD = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    logic stall = 1'b0;
    exe_bundle_t [NFU-1:0][EWD-1:0] resp;
    logic [NFU-1:0][EWD-1:0]        claim;
    exe_bundle_t [WWD-1:0]          wb;
    logic [1:0]                     prio;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0]      claim;
        logic [1:0]       prio;
        logic [3:0][15:0] wbo;
        bit               chk_wb;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   cyc_no = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.nfu(NFU), .ewd(EWD), .wwd(WWD)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .stall (stall),
        .resp  (resp),
        .claim (claim),
        .wb    (wb),
        .prio  (prio)
    );

    function automatic exe_bundle_t mk(input logic [15:0] op);
        exe_bundle_t b;
        b = '0;
        if (op[15]) begin
            b.opid  = op;
            b.npc   = {16'hABCD, op};
            b.cause = op[4:0] ^ 5'h15;
            b.prdv  = {op, ~op};
        end
        return b;
    endfunction

    task automatic set_unit(input int un, input int n, input logic [15:0] base);
        for (int i = 0; i < EWD; i++)
            resp[un][i] = (i < n) ? mk(base + 16'(i)) : '0;
    endtask

    task automatic all_full();
        set_unit(0, 4, 16'h8100);
        set_unit(1, 4, 16'h8200);
        set_unit(2, 4, 16'h8300);
    endtask

    task automatic step(input logic [11:0] c, input logic [1:0] p,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3,
                        input bit chk);
        exp_t e;
        e.claim  = c;
        e.prio   = p;
        e.wbo    = {w3, w2, w1, w0};
        e.chk_wb = chk;
        e.cyc    = cyc_no;
        q.push_back(e);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            exe_bundle_t ew;
            e = q.pop_front();
            checks++;
            if (claim !== e.claim) begin
                errors++;
                $display("FAIL claim cyc%0d: got %h want %h", e.cyc, claim, e.claim);
            end
            checks++;
            if (prio !== e.prio) begin
                errors++;
                $display("FAIL prio cyc%0d: got %0d want %0d", e.cyc, prio, e.prio);
            end
            if (e.chk_wb) begin
                for (int s = 0; s < WWD; s++) begin
                    ew = mk(e.wbo[s]);
                    checks++;
                    if (wb[s] !== ew) begin
                        errors++;
                        $display("FAIL wb[%0d] cyc%0d: got %h want %h", s, e.cyc, wb[s], ew);
                    end
                end
            end
        end
    end

    initial begin
        resp = '0;
        @(posedge clk);
        #1;
        // reset with all units full
        rst = 1'b1;
        all_full();
        step(12'h000, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        step(12'h000, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        // single unit
        rst = 1'b0;
        set_unit(0, 0, 16'h0);
        set_unit(1, 3, 16'h8001);
        set_unit(2, 0, 16'h0);
        step(12'h070, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        // contention and rotation
        all_full();
        step(12'h00F, 2'd0, 16'h8001, 16'h8002, 16'h8003, 16'h0, 1'b1);
        step(12'h0F0, 2'd1, 16'h8100, 16'h8101, 16'h8102, 16'h8103, 1'b1);
        step(12'hF00, 2'd2, 16'h8200, 16'h8201, 16'h8202, 16'h8203, 1'b1);
        step(12'h00F, 2'd0, 16'h8300, 16'h8301, 16'h8302, 16'h8303, 1'b1);
        step(12'h0F0, 2'd1, 16'h8100, 16'h8101, 16'h8102, 16'h8103, 1'b1);
        // split across units at prio 2
        set_unit(2, 1, 16'h8300);
        set_unit(0, 4, 16'h8100);
        set_unit(1, 2, 16'h8200);
        step(12'h107, 2'd2, 16'h8200, 16'h8201, 16'h8202, 16'h8203, 1'b1);
        // stall
        set_unit(0, 1, 16'h8010);
        set_unit(1, 0, 16'h0);
        set_unit(2, 0, 16'h0);
        step(12'h001, 2'd0, 16'h8300, 16'h8100, 16'h8101, 16'h8102, 1'b1);
        set_unit(0, 4, 16'h8020);
        set_unit(1, 1, 16'h8030);
        stall = 1'b1;
        step(12'h000, 2'd0, 16'h8010, 16'h0, 16'h0, 16'h0, 1'b1);
        step(12'h000, 2'd0, 16'h8010, 16'h0, 16'h0, 16'h0, 1'b1);
        step(12'h000, 2'd0, 16'h8010, 16'h0, 16'h0, 16'h0, 1'b1);
        stall = 1'b0;
        step(12'h00F, 2'd0, 16'h8010, 16'h0, 16'h0, 16'h0, 1'b1);
        // flush
        all_full();
        flush = 1'b1;
        step(12'h000, 2'd1, 16'h8020, 16'h8021, 16'h8022, 16'h8023, 1'b1);
        flush = 1'b0;
        step(12'h0F0, 2'd1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        // empty input
        resp = '0;
        step(12'h000, 2'd2, 16'h8200, 16'h8201, 16'h8202, 16'h8203, 1'b1);
        step(12'h000, 2'd2, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        // rst and flush together
        all_full();
        rst   = 1'b1;
        flush = 1'b1;
        step(12'h000, 2'd2, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        rst   = 1'b0;
        flush = 1'b0;
        resp  = '0;
        step(12'h000, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that sits directly downstream of the execution units (ALU, and peers with the same `resp`/`claim` queue interface). Each cycle it selects up to `wwd` completed results from `nfu` execution queues using rotating priority across units, and returns prefix-shaped `claim` signals so each unit pops exactly what was taken. It registers the selected `exe_bundle_t` results onto the writeback ports that feed the register file and reorder buffer.

## Interface
- `nfu`, 3: number of execution units arbitrated.
- `ewd`, 4: result ports per execution unit (width of each unit's `resp`/`claim`).
- `wwd`, 4: writeback ports; `wwd` ≥ 1.
- `clk`  in  1: clock. One clock domain.
- `rst`  in  1: reset; synchronous, active-high.
- `flush`  in  1: pipeline flush; synchronous, active-high.
- `stall`  in  1: the writeback consumer cannot accept new results this cycle.
- `resp`  in  `exe_bundle_t [nfu-1:0][ewd-1:0]`: unit results. An entry is valid iff `opid[15]`. Valid entries of one unit always form a prefix, indices `0..k-1`.
- `claim`  out  `logic [nfu-1:0][ewd-1:0]`: combinational take signals. Per unit, asserted bits always form a prefix.
- `wb`  out  `exe_bundle_t [wwd-1:0]`: registered writeback results. A slot is valid iff `opid[15]`; invalid slots are all-zero.
- `prio`  out  `$clog2(nfu)` bits (min 1): current highest-priority unit, for debug and coverage.

## Operation
- The scan order is units `prio, prio+1, …, nfu-1, 0, …, prio-1`, taken modulo `nfu`.
- Entries are taken greedily in scan order:
  - Within a unit, take entries `0,1,2…` while the entry is valid and a free writeback slot remains.
  - Stop that unit at its first invalid entry or when slots run out, then move to the next unit.
  - Once all `wwd` slots are filled, take nothing further from any unit.
- `claim[u][i]` = 1 iff entry `(u,i)` is taken this cycle. Because of the rule above, claims are a prefix per unit, which matches unit queues that pop from the front by count.
- Taken entries fill writeback slots in take order, slot 0 first, densely. Remaining slots are zero.
- **Suppression:** when `stall` or `flush` is high, all `claim` bits are 0 and nothing is taken.
- **Contention:** occurs when at least one valid entry remains unclaimed in a cycle that is not suppressed.
- **Priority update:** on contention, `prio` ← `(prio+1) mod nfu`; otherwise `prio` holds. `prio` is never changed by `flush`.
- **`wb` register update:**
  - `rst` or `flush`: all slots cleared to 0.
  - else `stall`: hold the current value.
  - else: load this cycle's selection, with zeros in unused slots.
- Result bundles pass through bit-exact. The arbiter never alters `npc`, `cause`, `prdv` or any other field.

## Timing
- **Reset values:** `wb` all zero (every `opid` = 0), `prio` = 0, `claim` = 0 while `rst` is high.
- **Latency:** a result claimed in cycle t appears on `wb` in cycle t+1. Throughput is up to `wwd` results per cycle.
- `claim` depends combinationally on `resp`, `prio`, `stall`, `flush`. It has no path from `wb`.
- **Stall:** a result already in `wb` remains visible for every stall cycle and the first cycle after stall deasserts. The consumer samples `wb` on its first non-stalled edge.
- **Flush:** results claimed in the flush cycle do not exist, because no claims are issued. `wb` reads zero the cycle after `flush`.
- **`rst` and `flush` together:** `rst` dominates. Same visible effect, and `prio` resets to 0.
- **`prio` wrap-around:** `nfu-1` → 0.
- **Unit count 1:** `prio` is constant 0.
- **Empty input:** no claims, `wb` ← zeros, `prio` holds.
- **Full demand** (`nfu·ewd` valid entries > `wwd`): exactly `wwd` claims per cycle; the unit at `prio` is always served first.

## Test plan
1. **Reset.** Hold `rst` 2 cycles with all `resp` valid. Required:
   - `claim` = 0 and `prio` = 0 during reset.
   - All `wb.opid` = 0 on the cycle after release.
2. **Single unit.** Unit 1 has 3 valid entries (`opid` 0x8001–0x8003); units 0 and 2 are empty. Required:
   - `claim[1]` = 4'b0111 and the other claims are 0.
   - Next cycle `wb[0..2].opid` = 0x8001, 0x8002, 0x8003, `wb[3].opid` = 0, and `prio` remains 0.
3. **Contention and rotation.** All units present 4 valid entries every cycle. Required:
   - Cycle 1 (`prio`=0): `claim[0]`=4'b1111, other claims 0.
   - Cycle 2 (`prio`=1): `claim[1]`=4'b1111.
   - `prio` sequence is 0,1,2,0 over four cycles.
4. **Split across units.** `prio`=2; unit 2 has 1 valid entry, unit 0 has 4, unit 1 has 2. Required:
   - `claim[2]`=0001, `claim[0]`=0111, `claim[1]`=0000.
   - `wb` order is u2e0, u0e0, u0e1, u0e2, and `prio` becomes 0.
5. **Stall.** Load `wb` with 0x8010 in slot 0, then raise `stall` for 3 cycles while unit 0 holds valid entries. Required:
   - `claim` = 0 throughout and `wb[0].opid` stays 0x8010.
   - On the first unstalled cycle, unit 0 is claimed and `wb` updates one cycle later.
6. **Flush.** Raise `flush` in a cycle with valid inputs and a non-empty `wb`. Required:
   - `claim` = 0 in the flush cycle and `wb` all zero the next cycle.
   - `prio` is unchanged.
   - The cycle after `flush`, normal claiming resumes.
